// File: rtl/threedo_chain_sched_pkg.sv
// threedo_chain_sched_pkg: shared 3DO controller-chain constants and scheduler state encoding
package threedo_chain_sched_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  localparam int DEFAULT_BITS = 16;
  localparam int MAX_PADS = 4;
endpackage

// File: rtl/threedo_chain_sched_sync_edge.sv
// sync_edge: two-flop synchronizer with rise/fall detection on the synchronized level
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [2:0] sh_q, sh_d;
  // shift the async input through two metastability flops and one history flop
  always_comb sh_d = {sh_q[1:0], async_in};
  // async reset clears the whole chain so no spurious edge appears after reset
  always_ff @(posedge clk or posedge rst)
    if (rst) sh_q <= '0;
    else sh_q <= sh_d;
  assign level = sh_q[1];
  assign rise = sh_q[1] & ~sh_q[2];
  assign fall = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/threedo_chain_sched.sv
// threedo_chain_sched: emulates a 3DO pad daisy chain, shifting snapshotted pad reports out on dat
module threedo_chain_sched import threedo_chain_sched_pkg::*; #(
  parameter int NUM_PADS = 2,
  parameter int BITS = DEFAULT_BITS
) (
  input  logic                     system_clock,
  input  logic                     reset,
  input  logic                     ps,
  input  logic                     clk,
  output logic                     dat,
  input  logic [NUM_PADS*BITS-1:0] pads,
  input  logic [NUM_PADS-1:0]      pad_present,
  output logic                     busy,
  output logic                     frame_done
);
  localparam int IW = NUM_PADS > 1 ? $clog2(NUM_PADS) : 1;
  localparam int CW = BITS > 1 ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  state_t state_q, state_d;
  logic [NUM_PADS-1:0][BITS-1:0] snap_q, snap_d;
  logic [NUM_PADS-1:0] pres_q, pres_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dat_q, dat_d, busy_q, busy_d, fd_q, fd_d;
  logic ps_lvl, ps_rise, ps_fall, clk_lvl, clk_rise, clk_fall;
  logic [IW:0] first_hit, next_hit;
  logic unused_edges;

  sync_edge u_ps (.clk(system_clock), .rst(reset), .async_in(ps), .level(ps_lvl), .rise(ps_rise), .fall(ps_fall));
  sync_edge u_clk (.clk(system_clock), .rst(reset), .async_in(clk), .level(clk_lvl), .rise(clk_rise), .fall(clk_fall));
  assign unused_edges = ^{ps_rise, ps_fall, clk_fall};

  // lowest present slot at or above 'from'; MSB flags whether one exists
  function automatic logic [IW:0] find_slot(input logic [NUM_PADS-1:0] p, input int from);
    find_slot = '0;
    for (int k = NUM_PADS - 1; k >= 0; k--)
      if (k >= from && p[k]) find_slot = {1'b1, IW'(k)};
  endfunction

  assign first_hit = find_slot(pad_present, 0);
  assign next_hit = find_slot(pres_q, int'(idx_q) + 1);

  // next-state logic: ps always wins, LOAD snapshots, SHIFT advances on console clk rises
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    snap_d = state_q == LOAD ? pads : snap_q;
    pres_d = state_q == LOAD ? pad_present : pres_q;
    if (ps_lvl) state_d = LOAD;
    else if (state_q == LOAD) begin
      state_d = first_hit[IW] ? SHIFT : DONE;
      idx_d = first_hit[IW-1:0];
      cnt_d = '0;
    end else if (state_q == SHIFT && clk_rise) begin
      cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
      idx_d = cnt_q == LAST && next_hit[IW] ? next_hit[IW-1:0] : idx_q;
      state_d = cnt_q == LAST && !next_hit[IW] ? DONE : SHIFT;
    end
    dat_d = state_d == LOAD ? 1'b1 :
            clk_lvl ? dat_q :
            state_d == SHIFT ? ~snap_d[idx_d][LAST - cnt_d] : 1'b1;
    busy_d = state_d == LOAD || state_d == SHIFT;
    fd_d = state_d == DONE && state_q != DONE;
  end

  // state and registered outputs, asynchronously reset to an idle, released line
  always_ff @(posedge system_clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      snap_q <= '0;
      pres_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      dat_q <= 1'b1;
      busy_q <= 1'b0;
      fd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q <= snap_d;
      pres_q <= pres_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      dat_q <= dat_d;
      busy_q <= busy_d;
      fd_q <= fd_d;
    end

  assign dat = dat_q;
  assign busy = busy_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_threedo_chain_sched.sv
// tb_threedo_chain_sched: randomized console-side stimulus checked against a bit-queue model of the chain
module tb_threedo_chain_sched;
  localparam int NP = 2;
  localparam int B = 16;

  logic system_clock = 1'b0;
  logic reset = 1'b1;
  logic ps = 1'b0;
  logic clk = 1'b0;
  logic dat, busy, frame_done;
  logic [NP*B-1:0] pads = '0;
  logic [NP-1:0] pad_present = '0;

  threedo_chain_sched #(.NUM_PADS(NP), .BITS(B)) dut (
    .system_clock(system_clock), .reset(reset), .ps(ps), .clk(clk), .dat(dat),
    .pads(pads), .pad_present(pad_present), .busy(busy), .frame_done(frame_done)
  );

  always #5 system_clock = ~system_clock;

  int n_chk = 0;
  int n_fail = 0;
  int fd_cnt = 0;
  int exp_fd = 0;
  int fd0;
  bit chk_en = 1'b0;
  bit exp_dat = 1'b1;
  bit exp_busy = 1'b0;
  bit fd_prev = 1'b0;
  bit q[$];
  logic [63:0] cap = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge system_clock);
    #2;
  endtask

  // every settled cycle: DUT outputs against the model, frame_done counted and kept to one cycle
  always @(negedge system_clock) begin
    if (frame_done) fd_cnt++;
    if (!reset) check("fd_width", frame_done & fd_prev, 0);
    fd_prev = frame_done;
    if (chk_en) begin
      check("dat", dat, exp_dat);
      check("busy", busy, exp_busy);
      check("frame_done_count", fd_cnt, exp_fd);
    end
  end

  task automatic load_frame();
    chk_en = 0;
    ps = 1;
    cyc(5);
    exp_dat = 1;
    exp_busy = 1;
    chk_en = 1;
    cyc(4);
    q.delete();
    for (int k = 0; k < NP; k++)
      if (pad_present[k])
        for (int b = B - 1; b >= 0; b--) q.push_back(~pads[k*B+b]);
    chk_en = 0;
    ps = 0;
    cyc(4);
    if (q.size() == 0) exp_fd++;
    check("fd_after_load", fd_cnt, exp_fd);
    exp_dat = q.size() > 0 ? q[0] : 1'b1;
    exp_busy = q.size() > 0;
    cyc(1);
    chk_en = 1;
    cyc(4);
  endtask

  task automatic pulse(input bit scramble);
    cap = {cap[62:0], dat};
    chk_en = 0;
    clk = 1;
    cyc(5);
    if (q.size() > 0) begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        exp_fd++;
        exp_busy = 0;
      end
    end
    chk_en = 1;
    cyc(3);
    chk_en = 0;
    clk = 0;
    if (scramble) begin
      pads = $urandom;
      pad_present = 2'($urandom_range(3));
    end
    exp_dat = q.size() > 0 ? q[0] : 1'b1;
    cyc(5);
    chk_en = 1;
    cyc(5);
  endtask

  initial begin
    cyc(3);
    check("rst_dat", dat, 1);
    check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0);
    reset = 0;
    cyc(2);
    chk_en = 1;
    repeat (3) pulse(0);

    pads = {16'h0003, 16'h8001};
    pad_present = 2'b11;
    fd0 = fd_cnt;
    load_frame();
    cap = '0;
    repeat (32) pulse(0);
    check("t1_stream", cap[31:0], 32'h7FFE_FFFC);
    check("t1_fd", fd_cnt - fd0, 1);
    repeat (2) pulse(0);
    check("t1_idle_ones", cap[1:0], 2'b11);

    pads = {16'hFFFF, 16'h1234};
    pad_present = 2'b10;
    fd0 = fd_cnt;
    load_frame();
    cap = '0;
    repeat (16) pulse(0);
    check("t2_stream", cap[15:0], 16'h0000);
    check("t2_fd", fd_cnt - fd0, 1);
    repeat (4) pulse(0);
    check("t2_no_slot0", cap[3:0], 4'hF);

    pad_present = 2'b00;
    fd0 = fd_cnt;
    load_frame();
    check("t3_fd", fd_cnt - fd0, 1);
    cap = '0;
    repeat (20) pulse(0);
    check("t3_ones", cap[19:0], 20'hFFFFF);

    pads = {16'h00F0, 16'hA5A5};
    pad_present = 2'b11;
    load_frame();
    repeat (5) pulse(0);
    fd0 = fd_cnt;
    load_frame();
    check("t4_abort_no_fd", fd_cnt - fd0, 0);
    cap = '0;
    repeat (32) pulse(0);
    check("t4_restart", cap[31:0], 32'h5A5A_FF0F);
    check("t4_fd", fd_cnt - fd0, 1);

    pads = {16'h1357, 16'h2468};
    pad_present = 2'b11;
    load_frame();
    cap = '0;
    repeat (32) pulse(1);
    check("t5_snapshot", cap[31:0], 32'hDB97_ECA8);

    repeat (12) begin
      pads = $urandom;
      pad_present = 2'($urandom_range(3));
      load_frame();
      repeat ($urandom_range(0, 40)) pulse($urandom_range(1));
    end

    pads = {16'h0000, 16'hFFFF};
    pad_present = 2'b11;
    load_frame();
    repeat (7) pulse(0);
    check("t6_pre_dat", dat, 0);
    check("t6_pre_busy", busy, 1);
    chk_en = 0;
    #1 reset = 1;
    #1;
    check("t6_async_dat", dat, 1);
    check("t6_async_busy", busy, 0);
    q.delete();
    exp_dat = 1;
    exp_busy = 0;
    cyc(2);
    reset = 0;
    cyc(2);
    chk_en = 1;
    fd0 = fd_cnt;
    repeat (5) pulse(0);
    check("t6_no_fd", fd_cnt - fd0, 0);
    load_frame();
    cap = '0;
    repeat (32) pulse(0);
    check("t6_recover", cap[31:0], 32'h0000_FFFF);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
